// File: rtl/ripple_count_monitor_pkg.sv
// rtl/ripple_count_monitor_pkg.sv - shared types and helpers for the ripple counter monitor
package ripple_count_monitor_pkg;

    typedef enum logic [1:0] {
        SEED  = 2'd0,
        TRACK = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam int CW_DEFAULT = 3;

    function automatic logic [31:0] dec_mod(input logic [31:0] value, input int width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (value - 32'd1) & mask;
    endfunction

endpackage

// File: rtl/ripple_count_sync_filter.sv
// rtl/ripple_count_sync_filter.sv - synchroniser plus stability filter for ripple counter outputs
module ripple_count_sync_filter
    import ripple_count_monitor_pkg::*;
#(
    parameter int CW          = CW_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] cnt_in,
    input  logic [CW-1:0] cnt_value,
    input  logic          seed_mode,
    output logic [CW-1:0] cand,
    output logic          accept
);

    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC);

    logic [CW-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0] q_s;
    logic [CW-1:0] cand_q;
    logic [CW-1:0] cand_d;
    logic [SW-1:0] stab_q;
    logic [SW-1:0] stab_d;

    assign q_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
        end else begin
            sync_q[0] <= cnt_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        if (q_s != cand_q) begin
            cand_d = q_s;
            stab_d = SW'(1);
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + SW'(1);
        end
    end

    // Fires only on the edge where the run length reaches the threshold, so a
    // settled value is offered once; cand_d is exported so the edge that
    // fires accept also loads the matching value.
    assign accept = (stab_d == STAB_MAX)
                  && ((stab_q != STAB_MAX) || (q_s != cand_q))
                  && (seed_mode || (cand_d != cnt_value));
    assign cand   = cand_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q <= '1;
            stab_q <= '0;
        end else begin
            cand_q <= cand_d;
            stab_q <= stab_d;
        end
    end

endmodule

// File: rtl/ripple_count_monitor.sv
// rtl/ripple_count_monitor.sv - tracks a ripple down-counter, flags wraps, sequence errors and stalls
module ripple_count_monitor
    import ripple_count_monitor_pkg::*;
#(
    parameter int CW          = CW_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 2,
    parameter int TIMEOUT     = 256,
    parameter int WRAP_W      = 8,
    parameter int ERR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW-1:0]     cnt_in,
    input  logic              clr,
    output logic [CW-1:0]     cnt_value,
    output logic              cnt_valid,
    output logic              seeded,
    output logic              wrap,
    output logic              err,
    output logic              stall,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [ERR_W-1:0]  err_count
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cand;
    logic          accept;
    logic [TW-1:0] timer;
    logic          step_ok;
    logic          do_check;
    logic          do_wrap;
    logic          do_err;
    logic          timer_run;
    logic          to_stall;

    ripple_count_sync_filter #(
        .CW          (CW),
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_CYC  (STABLE_CYC)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .cnt_value (cnt_value),
        .seed_mode (state_q == SEED),
        .cand      (cand),
        .accept    (accept)
    );

    assign step_ok = (cand == CW'(dec_mod(32'(cnt_value), CW)));
    assign do_wrap = do_check && step_ok && (cnt_value == '0);
    assign do_err  = do_check && !step_ok;

    always_comb begin
        state_d   = state_q;
        do_check  = 1'b0;
        timer_run = 1'b0;
        to_stall  = 1'b0;
        case (state_q)
            SEED: begin
                if (accept) state_d = TRACK;
            end
            TRACK: begin
                if (accept) begin
                    do_check = 1'b1;
                end else begin
                    timer_run = 1'b1;
                    if (timer == T_LAST) begin
                        to_stall = 1'b1;
                        state_d  = STALL;
                    end
                end
            end
            STALL: begin
                if (accept) begin
                    do_check = 1'b1;
                    state_d  = TRACK;
                end
            end
            default: state_d = SEED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEED;
            cnt_value  <= '1;
            cnt_valid  <= 1'b0;
            seeded     <= 1'b0;
            wrap       <= 1'b0;
            err        <= 1'b0;
            stall      <= 1'b0;
            timer      <= '0;
            wrap_count <= '0;
            err_count  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_valid <= accept;
            wrap      <= do_wrap;
            err       <= do_err;
            // Loading cand on an illegal step resyncs the next check to it.
            if (accept) begin
                cnt_value <= cand;
                seeded    <= 1'b1;
                timer     <= '0;
                stall     <= 1'b0;
            end else if (timer_run) begin
                timer <= timer + TW'(1);
            end
            if (to_stall) stall <= 1'b1;
            if (clr) begin
                wrap_count <= '0;
            end else if (do_wrap && (wrap_count != '1)) begin
                wrap_count <= wrap_count + WRAP_W'(1);
            end
            if (clr) begin
                err_count <= '0;
            end else if (do_err && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule
